// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-2 message scheduler: FSM states,
// sigma rotate/shift amounts for both word widths, and round counts.
package sha_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_FILL = 2'd2
    } sched_state_e;

    localparam int ROUNDS_SHA256 = 64;
    localparam int ROUNDS_SHA512 = 80;

    localparam int S0_R1_32 = 7;
    localparam int S0_R2_32 = 18;
    localparam int S0_SH_32 = 3;
    localparam int S1_R1_32 = 17;
    localparam int S1_R2_32 = 19;
    localparam int S1_SH_32 = 10;

    localparam int S0_R1_64 = 1;
    localparam int S0_R2_64 = 8;
    localparam int S0_SH_64 = 7;
    localparam int S1_R1_64 = 19;
    localparam int S1_R2_64 = 61;
    localparam int S1_SH_64 = 6;

endpackage

// File: rtl/msg_sigma.sv
// Small sigma function of the SHA-2 schedule: ROTR^ROTR^SHR.
// SEL=0 gives sigma0, SEL=1 gives sigma1; amounts follow WORD_W.
module msg_sigma
    import sha_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int SEL    = 0
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    localparam bit IS64 = (WORD_W == 64);
    localparam int R1 = IS64 ? ((SEL != 0) ? S1_R1_64 : S0_R1_64)
                             : ((SEL != 0) ? S1_R1_32 : S0_R1_32);
    localparam int R2 = IS64 ? ((SEL != 0) ? S1_R2_64 : S0_R2_64)
                             : ((SEL != 0) ? S1_R2_32 : S0_R2_32);
    localparam int SH = IS64 ? ((SEL != 0) ? S1_SH_64 : S0_SH_64)
                             : ((SEL != 0) ? S1_SH_32 : S0_SH_32);

    always_comb begin
        y = ((x >> R1) | (x << (WORD_W - R1)))
          ^ ((x >> R2) | (x << (WORD_W - R2)))
          ^ (x >> SH);
    end

endmodule

// File: rtl/msg_scheduler_param.sv
// SHA-2 message schedule generator: loads 16 message words, then streams
// W[0..ROUNDS-1] through a 16-deep window with valid/ready handshaking.
//
// state   | meaning
// LOAD    | accepting message words into window slot cnt
// RUN     | W[t] presented on out_word, waiting for out_ready
// FILL    | SERIAL=1 only: 3-cycle shared-adder accumulation of W[t+16]
module msg_scheduler_param
    import sha_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = ROUNDS_SHA256,
    parameter int SERIAL = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [6:0]        out_idx,
    output logic              block_done
);

    localparam logic [6:0] T_LAST  = 7'(ROUNDS - 1);
    localparam logic [6:0] T_APPND = 7'(ROUNDS - 16);

    sched_state_e      state, state_nxt;
    logic [3:0]        cnt;
    logic [6:0]        t;
    logic [1:0]        phase;
    logic [WORD_W-1:0] win [16];
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] s0, s1, add_a, add_b, add_sum, w_new;
    logic              in_fire, out_fire, do_shift, last_word, append;

    msg_sigma #(.WORD_W(WORD_W), .SEL(0)) u_sigma0 (.x(win[1]),  .y(s0));
    msg_sigma #(.WORD_W(WORD_W), .SEL(1)) u_sigma1 (.x(win[14]), .y(s1));

    assign last_word = (t == T_LAST);
    assign append    = (t < T_APPND);
    assign out_word  = win[0];
    assign out_idx   = t;

    // Shared adder sequence: win[0]+s0, then +win[9], then +s1 (lands in slot 15).
    always_comb begin
        add_a = (phase == 2'd0) ? win[0] : acc;
        add_b = s1;
        if (phase == 2'd0)
            add_b = s0;
        else if (phase == 2'd1)
            add_b = win[9];
        add_sum = add_a + add_b;
        if (SERIAL == 0)
            w_new = s1 + win[9] + s0 + win[0];
        else
            w_new = add_sum;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        in_fire   = 1'b0;
        out_fire  = 1'b0;
        do_shift  = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                in_fire  = in_valid;
                if (in_valid && cnt == 4'd15)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                out_valid = 1'b1;
                out_fire  = out_ready;
                if (out_ready) begin
                    if (last_word)
                        state_nxt = ST_LOAD;
                    else if (SERIAL != 0)
                        state_nxt = ST_FILL;
                    else
                        do_shift = 1'b1;
                end
            end
            ST_FILL: begin
                if (phase == 2'd2) begin
                    do_shift  = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
        if (abort)
            state_nxt = ST_LOAD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            t          <= '0;
            phase      <= '0;
            acc        <= '0;
            block_done <= 1'b0;
            for (int i = 0; i < 16; i++)
                win[i] <= '0;
        end else begin
            block_done <= 1'b0;
            if (abort) begin
                cnt   <= '0;
                t     <= '0;
                phase <= '0;
            end else begin
                if (in_fire) begin
                    win[cnt] <= in_word;
                    cnt      <= cnt + 4'd1;
                end
                if (state == ST_FILL) begin
                    if (phase != 2'd2)
                        acc <= add_sum;
                    phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                end
                if (do_shift) begin
                    for (int i = 0; i < 15; i++)
                        win[i] <= win[i+1];
                    win[15] <= append ? w_new : '0;
                    t       <= t + 7'd1;
                end
                if (out_fire && last_word) begin
                    t          <= '0;
                    cnt        <= '0;
                    block_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_msg_scheduler_param.sv
// Bench for msg_scheduler_param: three configurations (32/parallel,
// 32/serial, 64/parallel) checked against a bench-side SHA-2 schedule model.
module tb_msg_scheduler_param;

    logic        clk = 1'b0;
    logic        reset, abort;
    logic        in_valid_b, out_ready_b;
    logic [63:0] in_word_b;
    logic [1:0]  sel;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        ir0, ir1, ir2, ov0, ov1, ov2, bd0, bd1, bd2;
    logic [31:0] ow0, ow1;
    logic [63:0] ow2;
    logic [6:0]  oi0, oi1, oi2;
    logic        cur_ir, cur_ov, cur_bd;
    logic [63:0] cur_ow;
    logic [6:0]  cur_oi;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    msg_scheduler_param #(.WORD_W(32), .ROUNDS(64), .SERIAL(0)) u0 (
        .clk(clk), .reset(reset), .abort(abort),
        .in_valid(in_valid_b && sel == 2'd0), .in_ready(ir0), .in_word(in_word_b[31:0]),
        .out_valid(ov0), .out_ready(out_ready_b && sel == 2'd0), .out_word(ow0),
        .out_idx(oi0), .block_done(bd0));

    msg_scheduler_param #(.WORD_W(32), .ROUNDS(64), .SERIAL(1)) u1 (
        .clk(clk), .reset(reset), .abort(abort),
        .in_valid(in_valid_b && sel == 2'd1), .in_ready(ir1), .in_word(in_word_b[31:0]),
        .out_valid(ov1), .out_ready(out_ready_b && sel == 2'd1), .out_word(ow1),
        .out_idx(oi1), .block_done(bd1));

    msg_scheduler_param #(.WORD_W(64), .ROUNDS(80), .SERIAL(0)) u2 (
        .clk(clk), .reset(reset), .abort(abort),
        .in_valid(in_valid_b && sel == 2'd2), .in_ready(ir2), .in_word(in_word_b),
        .out_valid(ov2), .out_ready(out_ready_b && sel == 2'd2), .out_word(ow2),
        .out_idx(oi2), .block_done(bd2));

    always_comb begin
        cur_ir = ir0; cur_ov = ov0; cur_bd = bd0; cur_ow = {32'h0, ow0}; cur_oi = oi0;
        if (sel == 2'd1) begin
            cur_ir = ir1; cur_ov = ov1; cur_bd = bd1; cur_ow = {32'h0, ow1}; cur_oi = oi1;
        end else if (sel == 2'd2) begin
            cur_ir = ir2; cur_ov = ov2; cur_bd = bd2; cur_ow = ow2; cur_oi = oi2;
        end
    end

    typedef struct { logic [6:0] idx; logic [63:0] word; } exp_t;
    typedef struct { logic [1:0] sel; int idx; logic [63:0] word; } vec_t;

    exp_t        sbq[$];
    vec_t        vt[6];
    logic [63:0] msg[16];
    logic [63:0] gold[80];
    logic [63:0] cap[80];

    function automatic logic [31:0] r32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [63:0] r64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0d sel=%0d)", name, act, exp, cyc, sel);
        end
    endtask

    task automatic build_gold(input bit is64, input int rounds);
        logic [31:0] a32;
        logic [63:0] x2, x15;
        for (int i = 0; i < 16; i++) gold[i] = msg[i];
        for (int i = 16; i < rounds; i++) begin
            x2  = gold[i-2];
            x15 = gold[i-15];
            if (is64)
                gold[i] = (r64(x2, 19) ^ r64(x2, 61) ^ (x2 >> 6)) + gold[i-7]
                        + (r64(x15, 1) ^ r64(x15, 8) ^ (x15 >> 7)) + gold[i-16];
            else begin
                a32 = (r32(x2[31:0], 17) ^ r32(x2[31:0], 19) ^ (x2[31:0] >> 10))
                    + gold[i-7][31:0]
                    + (r32(x15[31:0], 7) ^ r32(x15[31:0], 18) ^ (x15[31:0] >> 3))
                    + gold[i-16][31:0];
                gold[i] = {32'h0, a32};
            end
        end
    endtask

    task automatic set_abc(input bit is64);
        for (int i = 0; i < 16; i++) msg[i] = 64'h0;
        msg[0]  = is64 ? 64'h6162638000000000 : 64'h0000000061626380;
        msg[15] = 64'h18;
    endtask

    task automatic set_rand(input bit is64);
        for (int i = 0; i < 16; i++)
            msg[i] = is64 ? {$urandom, $urandom} : {32'h0, $urandom};
    endtask

    task automatic load_block(input int rounds);
        exp_t e;
        chk("load_in_ready", {63'h0, cur_ir}, 64'h1);
        for (int i = 0; i < 16; i++) begin
            in_valid_b = 1'b1;
            in_word_b  = msg[i];
            @(negedge clk);
        end
        in_valid_b = 1'b0;
        chk("run_out_valid", {63'h0, cur_ov}, 64'h1);
        chk("run_first_idx", {57'h0, cur_oi}, 64'h0);
        sbq.delete();
        for (int i = 0; i < rounds; i++) begin
            e.idx  = 7'(i);
            e.word = gold[i];
            sbq.push_back(e);
        end
    endtask

    task automatic drain(input bit bp, input int abort_at, input int reset_at);
        bit          stall, have_hs, rdy;
        logic [63:0] pw;
        logic [6:0]  pi;
        int          last_hs;
        exp_t        e;
        stall = 0; have_hs = 0; last_hs = 0; pw = '0; pi = '0;
        for (int b = 0; b < 3000; b++) begin
            if (cur_bd) begin
                chk("done_queue_empty", 64'(sbq.size()), 64'h0);
                chk("done_latency", 64'(cyc - last_hs), 64'h1);
                out_ready_b = 1'b0; in_valid_b = 1'b0;
                @(negedge clk);
                chk("done_in_ready", {63'h0, cur_ir}, 64'h1);
                chk("done_out_valid", {63'h0, cur_ov}, 64'h0);
                chk("done_pulse_len", {63'h0, cur_bd}, 64'h0);
                return;
            end
            if (stall) begin
                chk("stall_valid", {63'h0, cur_ov}, 64'h1);
                chk("stall_word", cur_ow, pw);
                chk("stall_idx", {57'h0, cur_oi}, {57'h0, pi});
            end
            rdy        = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid_b = bp ? 1'($urandom_range(0, 1)) : 1'b0;
            in_word_b  = {$urandom, $urandom};
            stall = cur_ov && !rdy;
            pw = cur_ow; pi = cur_oi;
            if (cur_ov && int'(cur_oi) == abort_at) begin
                abort = 1'b1; out_ready_b = 1'b1; in_valid_b = 1'b0;
                @(negedge clk);
                abort = 1'b0; out_ready_b = 1'b0;
                chk("abort_out_valid", {63'h0, cur_ov}, 64'h0);
                chk("abort_idx", {57'h0, cur_oi}, 64'h0);
                chk("abort_no_done", {63'h0, cur_bd}, 64'h0);
                chk("abort_in_ready", {63'h0, cur_ir}, 64'h1);
                @(negedge clk);
                chk("abort_no_done_late", {63'h0, cur_bd}, 64'h0);
                sbq.delete();
                return;
            end
            if (cur_ov && int'(cur_oi) == reset_at) begin
                reset = 1'b1; out_ready_b = 1'b1; in_valid_b = 1'b0;
                @(negedge clk);
                reset = 1'b0; out_ready_b = 1'b0;
                chk("reset_out_valid", {63'h0, cur_ov}, 64'h0);
                chk("reset_in_ready", {63'h0, cur_ir}, 64'h1);
                chk("reset_idx", {57'h0, cur_oi}, 64'h0);
                chk("reset_no_done", {63'h0, cur_bd}, 64'h0);
                sbq.delete();
                return;
            end
            if (cur_ov && rdy) begin
                if (sbq.size() == 0) begin
                    chk("extra_word", {57'h0, cur_oi}, 64'hFFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("word", cur_ow, e.word);
                    chk("idx", {57'h0, cur_oi}, {57'h0, e.idx});
                end
                cap[cur_oi] = cur_ow;
                if (!bp && have_hs)
                    chk("hs_spacing", 64'(cyc - last_hs), (sel == 2'd1) ? 64'd4 : 64'd1);
                last_hs = cyc;
                have_hs = 1;
            end
            out_ready_b = rdy;
            @(negedge clk);
        end
        out_ready_b = 1'b0; in_valid_b = 1'b0;
        chk("timeout_block_done", 64'h0, 64'h1);
    endtask

    task automatic run_block(input logic [1:0] s, input bit bp, input int abort_at, input int reset_at);
        int rounds;
        rounds = (s == 2'd2) ? 80 : 64;
        sel = s;
        @(negedge clk);
        build_gold(s == 2'd2, rounds);
        load_block(rounds);
        drain(bp, abort_at, reset_at);
    endtask

    task automatic check_table(input logic [1:0] s);
        for (int k = 0; k < 6; k++)
            if (vt[k].sel == s) begin
                chk("abc_vector", cap[vt[k].idx], vt[k].word);
                chk("abc_model", gold[vt[k].idx], vt[k].word);
            end
    endtask

    initial begin
        vt[0] = '{2'd0, 16, 64'h0000000061626380};
        vt[1] = '{2'd0, 17, 64'h00000000000F0000};
        vt[2] = '{2'd1, 16, 64'h0000000061626380};
        vt[3] = '{2'd1, 17, 64'h00000000000F0000};
        vt[4] = '{2'd2, 16, 64'h6162638000000000};
        vt[5] = '{2'd2, 17, 64'h00030000000000C0};

        sel = 2'd0; reset = 1'b1; abort = 1'b0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; in_word_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready0", {63'h0, ir0}, 64'h1);
        chk("rst_in_ready1", {63'h0, ir1}, 64'h1);
        chk("rst_in_ready2", {63'h0, ir2}, 64'h1);
        chk("rst_out_valid", {61'h0, ov0, ov1, ov2}, 64'h0);
        chk("rst_done", {61'h0, bd0, bd1, bd2}, 64'h0);
        chk("rst_idx0", {57'h0, oi0}, 64'h0);
        chk("rst_idx1", {57'h0, oi1}, 64'h0);
        chk("rst_idx2", {57'h0, oi2}, 64'h0);
        chk("rst_word0", {32'h0, ow0}, 64'h0);
        chk("rst_word2", ow2, 64'h0);
        reset = 1'b0;

        set_abc(1'b0); run_block(2'd0, 1'b0, -1, -1); check_table(2'd0);
        set_abc(1'b0); run_block(2'd1, 1'b0, -1, -1); check_table(2'd1);
        set_abc(1'b1); run_block(2'd2, 1'b0, -1, -1); check_table(2'd2);

        set_rand(1'b0); run_block(2'd0, 1'b1, -1, -1);
        set_rand(1'b0); run_block(2'd1, 1'b1, -1, -1);
        set_rand(1'b1); run_block(2'd2, 1'b1, -1, -1);

        set_rand(1'b0); run_block(2'd0, 1'b0, 20, -1);
        set_rand(1'b0); run_block(2'd0, 1'b0, -1, -1);
        set_rand(1'b0); run_block(2'd1, 1'b0, 20, -1);
        set_rand(1'b0); run_block(2'd1, 1'b0, -1, -1);

        set_rand(1'b0); run_block(2'd0, 1'b0, -1, 40);
        set_rand(1'b0); run_block(2'd0, 1'b0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
